// File: rtl/gf_mult_pkg.sv
// Shared types and helpers for the digit-serial GF(2) multiplier.
// Holds the FSM state encoding, digit-count sizing and a carry-less multiply primitive.
package gf_mult_pkg;

   localparam int unsigned CLMUL_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int unsigned num_digits(input int unsigned w, input int unsigned d);
      return (d == 0) ? 32'd1 : w / d;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 32'd1 : 32'($clog2(n));
   endfunction

   // Carry-less product of a by the low d bits of digit.
   function automatic logic [2*CLMUL_MAX_W-1:0] clmul(input logic [CLMUL_MAX_W-1:0] a,
                                                      input logic [CLMUL_MAX_W-1:0] digit,
                                                      input int unsigned d);
      logic [2*CLMUL_MAX_W-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < CLMUL_MAX_W; i++) begin
         if (i < d && digit[i]) p = p ^ ((2*CLMUL_MAX_W)'(a) << i);
      end
      return p;
   endfunction

endpackage

// File: rtl/gf_digit_step.sv
// One Horner step: shift the accumulator by a digit and add a*digit,
// optionally folding the overflow back below x^W with the field polynomial.
module gf_digit_step
   import gf_mult_pkg::*;
#(
   parameter int unsigned W = 32,
   parameter int unsigned D = 4
) (
   input  logic [2*W-1:0] acc,
   input  logic [W-1:0]   a,
   input  logic [D-1:0]   digit,
   input  logic [W-1:0]   poly,
   input  logic           reduce,
   output logic [2*W-1:0] next_acc
);

   localparam int unsigned TW = W + D;

   logic [TW-1:0] prod;
   logic [TW-1:0] fpoly;
   logic [TW-1:0] t;

   always_comb begin
      prod  = TW'(clmul(CLMUL_MAX_W'(a), CLMUL_MAX_W'(digit), D));
      fpoly = TW'({1'b1, poly});
      t     = {acc[W-1:0], {D{1'b0}}} ^ prod;
      // Clear the D overflow bits from the top down; each fold may set lower ones.
      for (int k = int'(TW) - 1; k >= int'(W); k--) begin
         if (t[k]) t = t ^ (fpoly << (k - int'(W)));
      end
      if (reduce) next_acc = (2*W)'(t[W-1:0]);
      else        next_acc = (acc << D) ^ (2*W)'(prod);
   end

endmodule

// File: rtl/gf_digit_serial_mult.sv
// Digit-serial carry-less multiplier, MSB digit first, with optional reduction
// modulo x^W + poly. One operation in flight; valid/ready on both sides.
module gf_digit_serial_mult
   import gf_mult_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DIGIT_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_mult_a,
   input  logic [DATA_WIDTH-1:0]   in_mult_b,
   input  logic [DATA_WIDTH-1:0]   in_poly,
   input  logic                    in_reduce,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out_mult_result
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned D  = DIGIT_WIDTH;
   localparam int unsigned N  = num_digits(W, D);
   localparam int unsigned CW = cnt_width(N);

   if (D < 1 || D > W || (W % D) != 0 || W > CLMUL_MAX_W) begin : g_bad_params
      $error("gf_digit_serial_mult: DIGIT_WIDTH must divide DATA_WIDTH (1..DATA_WIDTH, width <= 64)");
   end

   state_e          state_q;
   state_e          state_d;
   logic            accept_c;
   logic            last_c;

   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    poly_q;
   logic            reduce_q;
   logic [2*W-1:0]  acc_q;
   logic [CW-1:0]   cnt_q;
   logic [D-1:0]    digit_c;
   logic [2*W-1:0]  acc_next_c;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      last_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept_c = 1'b1;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               last_c  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign digit_c = D'(b_q >> (32'(cnt_q) * D));

   gf_digit_step #(
      .W (W),
      .D (D)
   ) u_step (
      .acc      (acc_q),
      .a        (a_q),
      .digit    (digit_c),
      .poly     (poly_q),
      .reduce   (reduce_q),
      .next_acc (acc_next_c)
   );

   // Operand capture, Horner accumulation and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready        <= 1'b0;
         out_valid       <= 1'b0;
         out_mult_result <= '0;
         a_q             <= '0;
         b_q             <= '0;
         poly_q          <= '0;
         reduce_q        <= 1'b0;
         acc_q           <= '0;
         cnt_q           <= '0;
      end else begin
         in_ready  <= (state_d == IDLE);
         out_valid <= (state_d == DONE);
         if (accept_c) begin
            a_q      <= in_mult_a;
            b_q      <= in_mult_b;
            poly_q   <= in_poly;
            reduce_q <= in_reduce;
            acc_q    <= '0;
            cnt_q    <= CW'(N - 1);
         end else if (state_q == BUSY) begin
            acc_q <= acc_next_c;
            if (last_c) out_mult_result <= acc_next_c;
            else        cnt_q           <= cnt_q - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_gf_digit_serial_mult.sv
// Bench for gf_digit_serial_mult: directed GF(2^8) vectors on three digit widths
// and a randomized W=32 run against a bit-serial shift-and-reduce model.
module tb_gf_digit_serial_mult;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Bit-serial reference: r = r*x (mod f) then add a when the multiplier bit is set.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] p, input logic red, input int w);
      logic [63:0] r;
      logic [63:0] fp;
      r  = '0;
      fp = (64'd1 << w) | 64'(p);
      for (int i = w - 1; i >= 0; i--) begin
         r = r << 1;
         if (red && r[w]) r = r ^ fp;
         if (b[i]) r = r ^ 64'(a);
      end
      return r;
   endfunction

   // W=8 instances with D=2, D=1, D=8 sharing operand inputs
   logic [7:0]  a8, b8, p8;
   logic        red8;
   logic [2:0]  iv8, ir8, ov8, or8;
   logic [15:0] res8 [3];

   gf_digit_serial_mult #(.DATA_WIDTH(8), .DIGIT_WIDTH(2)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(iv8[0]), .in_ready(ir8[0]),
      .in_mult_a(a8), .in_mult_b(b8), .in_poly(p8), .in_reduce(red8),
      .out_valid(ov8[0]), .out_ready(or8[0]), .out_mult_result(res8[0]));

   gf_digit_serial_mult #(.DATA_WIDTH(8), .DIGIT_WIDTH(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(iv8[1]), .in_ready(ir8[1]),
      .in_mult_a(a8), .in_mult_b(b8), .in_poly(p8), .in_reduce(red8),
      .out_valid(ov8[1]), .out_ready(or8[1]), .out_mult_result(res8[1]));

   gf_digit_serial_mult #(.DATA_WIDTH(8), .DIGIT_WIDTH(8)) u_d8 (
      .clk(clk), .rst(rst), .in_valid(iv8[2]), .in_ready(ir8[2]),
      .in_mult_a(a8), .in_mult_b(b8), .in_poly(p8), .in_reduce(red8),
      .out_valid(ov8[2]), .out_ready(or8[2]), .out_mult_result(res8[2]));

   logic [31:0] a32, b32, p32;
   logic        red32, iv32, ir32, ov32, or32;
   logic [63:0] res32;

   gf_digit_serial_mult #(.DATA_WIDTH(32), .DIGIT_WIDTH(4)) u_w32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
      .in_mult_a(a32), .in_mult_b(b32), .in_poly(p32), .in_reduce(red32),
      .out_valid(ov32), .out_ready(or32), .out_mult_result(res32));

   // One operation on W=8 instance idx, entered and left #1 after a rising edge.
   task automatic op8(input int idx, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] p, input logic red, input logic [15:0] exp,
                      input int lat_exp, input string name);
      int lat;
      int g;
      g = 0;
      while (!ir8[idx] && g < 50) begin @(posedge clk); #1; g++; end
      a8 = a; b8 = b; p8 = p; red8 = red;
      iv8[idx] = 1'b1;
      or8[idx] = 1'b1;
      @(posedge clk); #1;
      iv8[idx] = 1'b0;
      lat = 1;
      while (!ov8[idx] && lat < 40) begin @(posedge clk); #1; lat++; end
      chk({name, "_latency"}, 64'(lat), 64'(lat_exp));
      chk({name, "_result"}, 64'(res8[idx]), 64'(exp));
      @(posedge clk); #1;
      chk({name, "_handshake"}, 64'({ov8[idx], ir8[idx]}), 64'(2'b01));
   endtask

   // Random-run monitor: expected results queued at accept, checked at output handshake.
   logic        rnd_on = 1'b0;
   logic [63:0] expq [$];
   int          nout = 0;
   logic        last_hold = 1'b0;
   logic [63:0] last_res = '0;

   always @(posedge clk) begin
      #1;
      if (rnd_on) or32 = ($urandom_range(0, 3) != 0);
   end

   always @(negedge clk) begin
      if (rnd_on && !rst) begin
         if (last_hold) begin
            chk("rnd_hold_valid", 64'(ov32), 64'd1);
            chk("rnd_hold_result", res32, last_res);
         end
         last_hold = ov32 && !or32;
         last_res  = res32;
         if (ov32 && or32) begin
            if (expq.size() == 0) chk("rnd_unexpected_output", 64'd1, 64'd0);
            else chk("rnd_result", res32, expq.pop_front());
            nout++;
         end
         if (iv32 && ir32) expq.push_back(ref_mul(a32, b32, p32, red32, 32));
      end
   end

   initial begin
      int g;
      logic [15:0] hold;
      rst = 1'b1;
      iv8 = '0; or8 = '0; a8 = '0; b8 = '0; p8 = '0; red8 = 1'b0;
      iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; p32 = 32'h8d; red32 = 1'b0;

      chk("model_full_57x83", ref_mul(32'h57, 32'h83, 32'h0, 1'b0, 8), 64'h2b79);
      chk("model_red_57x83", ref_mul(32'h57, 32'h83, 32'h1b, 1'b1, 8), 64'hc1);
      chk("model_full_ffxff", ref_mul(32'hff, 32'hff, 32'h0, 1'b0, 8), 64'h5555);
      chk("model_red32_x32", ref_mul(32'h8000_0000, 32'h2, 32'h8d, 1'b1, 32), 64'h8d);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({ov8, ov32, ir8, ir32}), 64'd0);
      chk("reset_results", {res8[0], res8[1], res8[2], 16'h0}, 64'd0);
      chk("reset_result32", res32, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", 64'({ir8, ir32}), 64'(4'b1111));

      op8(0, 8'h57, 8'h83, 8'h00, 1'b0, 16'h2b79, 5, "d2_full");
      op8(0, 8'h57, 8'h83, 8'h1b, 1'b1, 16'h00c1, 5, "d2_red");
      op8(0, 8'hff, 8'hff, 8'h1b, 1'b0, 16'h5555, 5, "d2_ff");
      op8(0, 8'h00, 8'h83, 8'h1b, 1'b0, 16'h0000, 5, "d2_zero");
      op8(1, 8'h57, 8'h83, 8'h00, 1'b0, 16'h2b79, 9, "d1_full");
      op8(1, 8'h57, 8'h83, 8'h1b, 1'b1, 16'h00c1, 9, "d1_red");
      op8(2, 8'h57, 8'h83, 8'h00, 1'b0, 16'h2b79, 2, "d8_full");
      op8(2, 8'h57, 8'h83, 8'h1b, 1'b1, 16'h00c1, 2, "d8_red");

      // Backpressure with in_valid held and operands changed mid-operation
      a8 = 8'h57; b8 = 8'h83; red8 = 1'b0; iv8[0] = 1'b1; or8[0] = 1'b0;
      @(posedge clk); #1;
      a8 = 8'hff; b8 = 8'hff;
      g = 0;
      while (!ov8[0] && g < 40) begin @(posedge clk); #1; g++; end
      hold = res8[0];
      chk("bp_result", 64'(hold), 64'h2b79);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_stall", 64'({ov8[0], ir8[0], res8[0]}), 64'({1'b1, 1'b0, 16'h2b79}));
      end
      or8[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", 64'({ov8[0], ir8[0]}), 64'(2'b01));
      @(posedge clk); #1;
      iv8[0] = 1'b0;
      chk("bp_next_accept", 64'(ir8[0]), 64'd0);
      g = 0;
      while (!ov8[0] && g < 40) begin @(posedge clk); #1; g++; end
      chk("bp_second_result", 64'(res8[0]), 64'h5555);
      @(posedge clk); #1;

      // Reset during the second BUSY cycle
      a8 = 8'h57; b8 = 8'h83; p8 = 8'h1b; red8 = 1'b1; iv8[0] = 1'b1; or8[0] = 1'b1;
      @(posedge clk); #1;
      iv8[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_outputs", 64'({ov8[0], ir8[0]}), 64'd0);
      chk("midrst_result", 64'(res8[0]), 64'd0);
      @(posedge clk); #1;
      chk("midrst_idle", 64'(ir8[0]), 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("midrst_no_emit", 64'({ov8[0], res8[0]}), 64'd0);
      end
      op8(0, 8'h57, 8'h83, 8'h1b, 1'b1, 16'h00c1, 5, "post_rst_red");

      // Randomized W=32 run with throttling on both sides
      p32 = 32'h0000_008d;
      rnd_on = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         a32 = $urandom; b32 = $urandom; red32 = 1'($urandom_range(0, 1));
         iv32 = 1'b1;
         g = 0;
         do begin @(negedge clk); g++; end while (!ir32 && g < 200);
         if (!ir32) chk("rnd_ready_timeout", 64'd0, 64'd1);
         @(posedge clk); #1;
         iv32 = 1'b0;
         a32 = $urandom; b32 = $urandom; red32 = 1'($urandom_range(0, 1));
      end
      g = 0;
      while (nout < 1000 && g < 2000) begin @(posedge clk); g++; end
      rnd_on = 1'b0;
      chk("rnd_output_count", 64'(nout), 64'd1000);
      chk("rnd_queue_empty", 64'(expq.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
